// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch buffer between instruction memory and decode
// Credit-limited in-order fetch with redirect flush of buffered and in-flight fetches.
module fetch_queue #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int PC_INC   = 1,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    newPC,
  input  logic               jorb,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    PCPlus1,
  output logic               valid,
  input  logic               ready,
  output logic               idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_W-1:0] LP_INC    = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] LP_RST_PC = PC_W'(RESET_PC);
  localparam logic [CW:0]     LP_DEPTH  = (CW+1)'(DEPTH);

  logic [PC_W-1:0]    r_fetch_pc;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_outstanding;
  logic [CW-1:0]      r_discard;
  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [AW-1:0]      r_pq_rd;
  logic [AW-1:0]      r_pq_wr;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [PC_W-1:0]    r_pq_mem    [DEPTH];
  logic               r_armed;

  logic        w_req;
  logic        w_resp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [CW:0] w_credit;

  // Buffered plus in-flight never exceeds DEPTH, so neither FIFO can overflow.
  assign w_credit = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req    = rst & ~halt & ~jorb & (w_credit < LP_DEPTH);
  assign w_resp   = imem_rvalid & (r_outstanding != '0);
  assign w_drop   = w_resp & (r_discard != '0);
  assign w_push   = w_resp & ~w_drop & ~jorb;
  assign w_pop    = (r_count != '0) & ready & ~jorb;

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign valid     = (r_count != '0);
  assign instr     = r_instr_mem[r_head];
  assign PC        = r_pc_mem[r_head];
  assign PCPlus1   = PC + LP_INC;
  assign idle      = halt & (r_count == '0) & (r_outstanding == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= LP_RST_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_pq_rd       <= '0;
      r_pq_wr       <= '0;
      r_armed       <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req) - CW'(w_resp);
      if (w_req) begin
        r_pq_wr <= r_pq_wr + AW'(1);
        r_armed <= 1'b1;
      end
      if (w_resp) r_pq_rd <= r_pq_rd + AW'(1);
      // Every fetch still in flight after a redirect belongs to the old stream.
      if (jorb) begin
        r_fetch_pc <= newPC;
        r_discard  <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_req)  r_fetch_pc <= r_fetch_pc + LP_INC;
        if (w_drop) r_discard  <= r_discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req) r_pq_mem[r_pq_wr] <= r_fetch_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= LP_RST_PC;
      end
    end else if (jorb) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_instr_mem[r_tail] <= imem_rdata;
        r_pc_mem[r_tail]    <= r_pq_mem[r_pq_rd];
        r_tail              <= r_tail + AW'(1);
      end
      if (w_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Late responses before the first post-reset request are tolerated and ignored.
  always @(posedge clk) begin
    if (rst && r_armed && imem_rvalid)
      assert (r_outstanding != '0);
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a queue model
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] newPC = '0;
  logic        jorb = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] PC;
  logic [15:0] PCPlus1;
  logic        valid;
  logic        ready = 1'b0;
  logic        idle;

  fetch_queue dut (
    .clk(clk), .rst(rst), .newPC(newPC), .jorb(jorb), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .PC(PC), .PCPlus1(PCPlus1), .valid(valid),
    .ready(ready), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] pc; bit stale;} fl_t;
  typedef struct {logic [15:0] addr; int due;} mq_t;

  fl_t         fl[$];
  mq_t         mq[$];
  logic [15:0] bq[$];
  logic [15:0] m_fpc = '0;
  int          cyc = 0;
  int          lat = 1;
  bit          rand_lat = 0;
  bit          force_late = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit          rv;
    bit          exp_req;
    bit          push;
    logic [15:0] rpc;
    logic [15:0] p1;
    fl_t         e;
    int          l;
    rv = force_late || (mq.size() > 0 && mq[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = force_late ? 16'hDEAD : (rv ? mem_data(mq[0].addr) : 16'h0000);
    #1;
    exp_req = !halt && !jorb && (bq.size() + fl.size() < 4);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", 32'(imem_addr), 32'(m_fpc));
    check("valid", 32'(valid), 32'(bq.size() > 0));
    check("idle", 32'(idle), 32'(halt && bq.size() == 0 && fl.size() == 0));
    if (bq.size() > 0) begin
      p1 = bq[0] + 16'd1;
      check("PC", 32'(PC), 32'(bq[0]));
      check("instr", 32'(instr), 32'(mem_data(bq[0])));
      check("PCPlus1", 32'(PCPlus1), 32'(p1));
    end
    push = 0;
    rpc  = '0;
    if (rv && fl.size() > 0) begin
      e    = fl.pop_front();
      push = !e.stale && !jorb;
      rpc  = e.pc;
    end
    if (rv && !force_late && mq.size() > 0) mq.delete(0);
    if (bq.size() > 0 && ready && !jorb) bq.delete(0);
    if (push) bq.push_back(rpc);
    if (jorb) begin
      bq.delete();
      foreach (fl[i]) fl[i].stale = 1;
      m_fpc = newPC;
    end else if (exp_req) begin
      l = rand_lat ? int'($urandom_range(1, 4)) : lat;
      fl.push_back('{pc: m_fpc, stale: 0});
      mq.push_back('{addr: m_fpc, due: cyc + l});
      m_fpc = m_fpc + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    jorb       = 1'b0;
    force_late = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_PC", 32'(PC), 32'd0);
    check("rst_PCPlus1", 32'(PCPlus1), 32'd1);
    check("rst_idle_nohalt", 32'(idle), 32'd0);
    halt = 1'b1;
    #1;
    check("rst_idle_halt", 32'(idle), 32'd1);
    halt  = 1'b0;
    ready = 1'b1;
    rst   = 1'b1;

    // latency 1, streaming
    lat = 1;
    repeat (8) cycle();
    // decode stalled: buffer fills to DEPTH and requests stop
    ready = 1'b0;
    repeat (10) cycle();
    ready = 1'b1;
    repeat (6) cycle();

    // two fetches in flight at latency 3, then redirect to 0x0040
    lat = 3;
    jorb = 1'b1; newPC = 16'h0100;
    cycle();
    cycle();
    cycle();
    jorb = 1'b1; newPC = 16'h0040;
    cycle();
    repeat (12) cycle();

    // PC wrap
    lat = 1;
    jorb = 1'b1; newPC = 16'hFFFE;
    cycle();
    repeat (8) cycle();

    // halt with buffered and outstanding work, then resume
    lat = 2; ready = 1'b0;
    jorb = 1'b1; newPC = 16'h0200;
    cycle();
    repeat (3) cycle();
    halt = 1'b1;
    repeat (2) cycle();
    ready = 1'b1;
    repeat (6) cycle();
    halt = 1'b0;
    repeat (6) cycle();

    // random traffic
    rand_lat = 1;
    repeat (400) begin
      ready = ($urandom_range(0, 3) != 0);
      halt  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) begin
        jorb  = 1'b1;
        newPC = 16'($urandom);
      end
      cycle();
    end
    rand_lat = 0;
    halt = 1'b0;

    // asynchronous reset while valid
    lat = 2; ready = 1'b0;
    repeat (5) cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_PC", 32'(PC), 32'd0);
    check("arst_imem_addr", 32'(imem_addr), 32'd0);
    bq.delete();
    fl.delete();
    mq.delete();
    m_fpc = 16'h0000;
    halt = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    force_late = 1;
    cycle();
    cycle();
    halt = 1'b0; ready = 1'b1;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
